key_sched_ctrl: RTL and testbench
=================================

# key_sched_ctrl

Sequencer for the full AES-128 key schedule. It accepts a 16-byte cipher key as a byte stream and computes round keys 1..10 on one word-wide XOR datapath, sharing the external S-box through a request port. It stores all 11 round keys and streams any requested round key byte-by-byte to the cipher round logic. It sits between the key loader and the encryption rounds, replacing per-round key-expansion instances.

## Interface
- NR, 10: number of rounds; round keys 0..NR are stored.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  8  key byte.
- din_en  in  1  din valid; bytes taken in order 0..15.
- sbox_addr  out  8  S-box lookup address.
- sbox_en  out  1  lookup request; sbox_data valid exactly 1 cycle after sbox_en.
- sbox_data  in  8  S-box result.
- keys_ready  out  1  all 11 round keys valid.
- busy  out  1  loading or expanding.
- rk_req  in  1  single-cycle round-key request.
- rk_round  in  4  requested round 0..10.
- rk_dout  out  8  round-key byte.
- rk_valid  out  1  rk_dout valid.

## Operation
- Byte layout (codebase convention): byte k is at row k/4, column k%4. Word w_j = column j = bytes {j, j+4, j+8, j+12}.
- States: IDLE, LOAD, SUB, MIX, READY, SEND.
- IDLE: din_en goes to LOAD and captures byte 0 as round-key 0 byte 0.
  - Reset values: all outputs 0, rk_dout 0, sbox_addr 0, round counter 0.
- LOAD: each din_en cycle stores the next byte. The 16th byte sets round=1, cnt=0 and moves to SUB. busy is high from the first accepted byte.
- SUB, 5 cycles (cnt 0..4):
  - cnt 0..3: sbox_en=1, sbox_addr = RotWord(w3 of round-1) byte cnt. The order is bytes 7, 11, 15, 3.
  - cnt 1..4: capture sbox_data into temp[cnt-1].
  - After cnt 4, go to MIX.
- MIX, 4 cycles (col 0..3): new w0 = w0 ^ temp ^ {rcon[round],0,0,0}. For j = 1..3, new wj = wj ^ new w(j-1). One column is written per cycle into round slot `round`.
  - After col 3: if round==NR go to READY, else round+1 and go to SUB.
- READY: keys_ready=1, busy=0.
  - rk_req with rk_round ≤ 10 goes to SEND.
  - rk_round > 10 is ignored and the block stays in READY.
- SEND: emits bytes 0..15 of the requested round, one per cycle, with rk_valid=1, then returns to READY.
  - rk_req during SEND is ignored.
- din_en during SUB/MIX is ignored; the key is not restarted.
- din_en in READY or SEND starts a new key load with that byte as byte 0. keys_ready clears and any stream aborts.
- sbox_en is never asserted outside SUB.
- rcon is an 8-bit value applied to row 0 only. All XORs are 8-bit with no carries.

## Timing
- Let edge E0 be the edge that accepts byte 15.
  - Round r SUB occupies E(9r-8)..E(9r-4).
  - Round r MIX occupies E(9r-3)..E(9r).
  - keys_ready is high after E90. Total expansion is 90 cycles.
- S-box latency is fixed at 1 cycle. No stall input exists.
- rk_req sampled at edge T gives byte 0 on rk_dout/rk_valid after T+1 and byte 15 after T+16. rk_valid drops after T+17.
- A new rk_req is accepted in the first READY cycle after a stream.
- Abort: din_en in SEND drops rk_valid after the same edge.
- rst_n low at any time forces IDLE immediately, with all outputs 0. Stored keys are invalid until a new load completes.

## Structure
- Package aes_pkg: NR, the rcon table {01,02,04,08,10,20,40,80,1B,36}, and the state enum.
- Sub-module key_store: an 11×16-byte register array.
  - One column-write port: round, column, 4 bytes.
  - One byte-read port: round, byte index.
  - Combinational read of the w3 bytes of the previous round.
- The controller FSM, temp register, and counters live in key_sched_ctrl. Expected size is ~250 lines.

## Test plan
- FIPS-197 key, row-major stream 2b 28 ab 09 7e ae f7 cf 15 d2 15 4f 16 a6 88 3c, with a 1-cycle S-box model:
  - keys_ready rises 90 cycles after the last byte.
  - Round 1 reads a0 88 23 2a fa 54 a3 6c fe 2c 39 76 17 b1 39 05.
- Same key, request round 10 → d0 c9 e1 b6 14 ee 3f 63 f9 25 0c 0c a8 89 c8 a6.
  - rk_valid holds for exactly 16 cycles starting 1 cycle after rk_req.
- Request round 0 → the input key bytes echoed in order.
- Request rk_round=11 → no rk_valid and the block stays in READY.
- rk_req mid-stream → ignored, and the stream completes.
- din_en mid-expansion → ignored.
- din_en in SEND → rk_valid drops next edge, keys_ready clears, and the new key expands correctly.
- rst_n asserted during round 5 → all outputs 0 at once.
  - A fresh load afterwards gives correct round-10 output.
  - sbox_en pulses exactly 40 times per expansion.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key-schedule constants, round-constant table and controller states.
package aes_pkg;
   localparam int NR = 10;
   // Indexed by round number; entry 0 and 11..15 are padding so any 4-bit round indexes safely.
   localparam logic [15:0][7:0] RCON = {40'h0, 8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                         8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SUB, S_MIX, S_READY, S_SEND} state_e;
endpackage

// File: rtl/key_store.sv
// key_store: 11 x 16-byte round-key array with a column write port (byte enables), a byte read port
// and a combinational column read used by the expansion datapath.
module key_store
   import aes_pkg::*;
(
   input  logic            clk,
   input  logic            we_i,
   input  logic [3:0]      wr_round_i,
   input  logic [1:0]      wr_col_i,
   input  logic [3:0]      wr_be_i,
   input  logic [3:0][7:0] wr_data_i,
   input  logic [3:0]      rd_round_i,
   input  logic [3:0]      rd_idx_i,
   output logic [7:0]      rd_byte_o,
   input  logic [3:0]      col_round_i,
   input  logic [1:0]      col_sel_i,
   output logic [3:0][7:0] col_o
);
   logic [7:0] mem_q [NR+1][16];

   // Byte k lives at row k/4, column k%4, so a column entry is addressed as {row, col}.
   always_ff @(posedge clk)
      if (we_i)
         for (int r = 0; r < 4; r++)
            if (wr_be_i[r]) mem_q[wr_round_i][{r[1:0], wr_col_i}] <= wr_data_i[r];

   assign rd_byte_o = mem_q[rd_round_i][rd_idx_i];

   for (genvar g = 0; g < 4; g++) begin : g_col
      assign col_o[g] = mem_q[col_round_i][{2'(g), col_sel_i}];
   end
endmodule

// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: byte-serial AES-128 key loader, shared-S-box key expansion and round-key streamer.
module key_sched_ctrl
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] din,
   input  logic       din_en,
   output logic [7:0] sbox_addr,
   output logic       sbox_en,
   input  logic [7:0] sbox_data,
   output logic       keys_ready,
   output logic       busy,
   input  logic       rk_req,
   input  logic [3:0] rk_round,
   output logic [7:0] rk_dout,
   output logic       rk_valid
);
   state_e          state_q;
   logic [3:0]      cnt_q, round_q, rk_sel_q;
   logic [3:0][7:0] temp_q, last_q, mix_col_d, prev_col;
   logic            sbox_en_q, keys_ready_q, busy_q, rk_valid_q;
   logic [7:0]      sbox_addr_q, rk_dout_q, rd_byte;
   logic            load_we, mix_we;
   logic [3:0]      load_idx, col_round;

   assign load_we   = din_en && (state_q inside {S_IDLE, S_LOAD, S_READY, S_SEND});
   assign mix_we    = state_q == S_MIX;
   assign load_idx  = state_q == S_LOAD ? cnt_q : 4'd0;
   assign col_round = state_q == S_LOAD ? 4'd0 : round_q - 4'd1;

   // Column 0 folds in SubWord(RotWord(w3)) and rcon; later columns chain off the column just written.
   always_comb begin
      mix_col_d = '0;
      for (int r = 0; r < 4; r++)
         mix_col_d[r] = prev_col[r] ^ (cnt_q == 4'd0 ?
                        temp_q[r] ^ (r == 0 ? RCON[round_q] : 8'h00) : last_q[r]);
   end

   key_store u_store (
      .clk        (clk),
      .we_i       (load_we || mix_we),
      .wr_round_i (mix_we ? round_q : 4'd0),
      .wr_col_i   (mix_we ? cnt_q[1:0] : load_idx[1:0]),
      .wr_be_i    (mix_we ? 4'hf : 4'b0001 << load_idx[3:2]),
      .wr_data_i  (mix_we ? mix_col_d : {4{din}}),
      .rd_round_i (rk_sel_q),
      .rd_idx_i   (cnt_q),
      .rd_byte_o  (rd_byte),
      .col_round_i(col_round),
      .col_sel_i  (mix_we ? cnt_q[1:0] : 2'd3),
      .col_o      (prev_col)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         round_q      <= '0;
         rk_sel_q     <= '0;
         temp_q       <= '0;
         last_q       <= '0;
         sbox_en_q    <= 1'b0;
         sbox_addr_q  <= '0;
         keys_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         rk_valid_q   <= 1'b0;
         rk_dout_q    <= '0;
      end else if (load_we && state_q != S_LOAD) begin
         state_q      <= S_LOAD;
         cnt_q        <= 4'd1;
         busy_q       <= 1'b1;
         keys_ready_q <= 1'b0;
         rk_valid_q   <= 1'b0;
         rk_dout_q    <= '0;
      end else begin
         case (state_q)
            S_LOAD:
               if (din_en) begin
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == 4'd15) begin
                     state_q     <= S_SUB;
                     round_q     <= 4'd1;
                     cnt_q       <= '0;
                     sbox_en_q   <= 1'b1;
                     sbox_addr_q <= prev_col[1];
                  end
               end
            // Lookups are issued one cycle ahead; results arrive a cycle later into temp.
            S_SUB: begin
               if (cnt_q != 4'd0) temp_q[cnt_q[1:0] - 2'd1] <= sbox_data;
               sbox_en_q   <= cnt_q < 4'd3;
               sbox_addr_q <= cnt_q < 4'd3 ? prev_col[cnt_q[1:0] + 2'd2] : 8'h00;
               cnt_q       <= cnt_q == 4'd4 ? 4'd0 : cnt_q + 4'd1;
               if (cnt_q == 4'd4) state_q <= S_MIX;
            end
            S_MIX: begin
               last_q <= mix_col_d;
               cnt_q  <= cnt_q + 4'd1;
               if (cnt_q == 4'd3) begin
                  cnt_q <= '0;
                  if (round_q == 4'(NR)) begin
                     state_q      <= S_READY;
                     keys_ready_q <= 1'b1;
                     busy_q       <= 1'b0;
                  end else begin
                     state_q     <= S_SUB;
                     round_q     <= round_q + 4'd1;
                     sbox_en_q   <= 1'b1;
                     sbox_addr_q <= mix_col_d[1];
                  end
               end
            end
            S_READY: begin
               rk_valid_q <= 1'b0;
               rk_dout_q  <= '0;
               if (rk_req && rk_round <= 4'(NR)) begin
                  state_q  <= S_SEND;
                  rk_sel_q <= rk_round;
                  cnt_q    <= '0;
               end
            end
            S_SEND: begin
               rk_valid_q <= 1'b1;
               rk_dout_q  <= rd_byte;
               cnt_q      <= cnt_q + 4'd1;
               if (cnt_q == 4'd15) state_q <= S_READY;
            end
            default: ;
         endcase
      end
   end

   assign sbox_en    = sbox_en_q;
   assign sbox_addr  = sbox_addr_q;
   assign keys_ready = keys_ready_q;
   assign busy       = busy_q;
   assign rk_valid   = rk_valid_q;
   assign rk_dout    = rk_dout_q;
endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb_key_sched_ctrl: scoreboard bench for key_sched_ctrl with a 1-cycle S-box model and a reference key expansion.
module tb_key_sched_ctrl;
   logic       clk = 1'b0, rst_n = 1'b0, din_en = 1'b0, rk_req = 1'b0;
   logic [7:0] din = '0, sbox_data = '0;
   logic [3:0] rk_round = '0;
   logic [7:0] sbox_addr, rk_dout;
   logic       sbox_en, keys_ready, busy, rk_valid;

   int         n_cmp = 0, n_bad = 0, vcnt = 0, scnt = 0;
   logic [7:0] sbox_t [256];
   logic [7:0] rk_m [11][16];
   logic [7:0] exp_q [$];
   logic [7:0] key_a [16] = '{8'h2b, 8'h28, 8'hab, 8'h09, 8'h7e, 8'hae, 8'hf7, 8'hcf,
                              8'h15, 8'hd2, 8'h15, 8'h4f, 8'h16, 8'ha6, 8'h88, 8'h3c};
   logic [7:0] r1_f [16]  = '{8'ha0, 8'h88, 8'h23, 8'h2a, 8'hfa, 8'h54, 8'ha3, 8'h6c,
                              8'hfe, 8'h2c, 8'h39, 8'h76, 8'h17, 8'hb1, 8'h39, 8'h05};
   logic [7:0] r10_f [16] = '{8'hd0, 8'hc9, 8'he1, 8'hb6, 8'h14, 8'hee, 8'h3f, 8'h63,
                              8'hf9, 8'h25, 8'h0c, 8'h0c, 8'ha8, 8'h89, 8'hc8, 8'ha6};
   logic [7:0] key_b [16], key_c [16], key_d [16], e [16];

   key_sched_ctrl dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en),
      .sbox_addr(sbox_addr), .sbox_en(sbox_en), .sbox_data(sbox_data),
      .keys_ready(keys_ready), .busy(busy), .rk_req(rk_req), .rk_round(rk_round),
      .rk_dout(rk_dout), .rk_valid(rk_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      sbox_data <= sbox_en ? sbox_t[sbox_addr] : 8'h00;
      if (sbox_en) scnt <= scnt + 1;
   end

   always @(negedge clk)
      if (rk_valid) begin
         vcnt++;
         if (exp_q.size() == 0) check("rk_unexpected", 1, 0);
         else check("rk_byte", {24'h0, rk_dout}, {24'h0, exp_q.pop_front()});
      end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, r;
      logic [7:0] s;
      for (int x = 0; x < 256; x++) begin
         inv = '0;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ 8'h63;
         r = inv;
         for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s ^= r;
         end
         sbox_t[x] = s;
      end
   endtask

   task automatic model(input logic [7:0] k [16]);
      logic [7:0] t [4];
      logic [7:0] rc;
      rc = 8'h01;
      for (int i = 0; i < 16; i++) rk_m[0][i] = k[i];
      for (int r = 1; r <= 10; r++) begin
         for (int w = 0; w < 4; w++) t[w] = sbox_t[rk_m[r-1][((w + 1) % 4) * 4 + 3]];
         t[0] ^= rc;
         rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         for (int j = 0; j < 4; j++)
            for (int w = 0; w < 4; w++)
               rk_m[r][w*4+j] = rk_m[r-1][w*4+j] ^ (j == 0 ? t[w] : rk_m[r][w*4+j-1]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] k [16], input int from);
      for (int i = from; i < 16; i++) begin
         din    = k[i];
         din_en = 1'b1;
         tick();
      end
      din_en = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!keys_ready && n < 300) begin
         tick();
         n++;
      end
   endtask

   task automatic get_rk(input int r, output logic [7:0] o [16]);
      for (int i = 0; i < 16; i++) o[i] = rk_m[r][i];
   endtask

   task automatic request(input int r, input logic [7:0] x [16]);
      for (int i = 0; i < 16; i++) exp_q.push_back(x[i]);
      rk_round = 4'(r);
      rk_req   = 1'b1;
      tick();
      rk_req   = 1'b0;
   endtask

   task automatic stream(input string tag, input int r, input logic [7:0] x [16]);
      int v0;
      v0 = vcnt;
      request(r, x);
      check({tag, "_v_at_T"}, {31'h0, rk_valid}, 0);
      tick();
      check({tag, "_v_first"}, {31'h0, rk_valid}, 1);
      repeat (15) tick();
      check({tag, "_v_last"}, {31'h0, rk_valid}, 1);
      tick();
      check({tag, "_v_drop"}, {31'h0, rk_valid}, 0);
      check({tag, "_v_len"}, vcnt - v0, 16);
      check({tag, "_q_empty"}, exp_q.size(), 0);
   endtask

   task automatic expand(input string tag, input logic [7:0] k [16]);
      int n, s0;
      model(k);
      s0 = scnt;
      load(k, 0);
      check({tag, "_busy"}, {31'h0, busy}, 1);
      wait_ready(n);
      check({tag, "_latency"}, n, 90);
      check({tag, "_sbox_pulses"}, scnt - s0, 40);
   endtask

   initial begin
      int n, s0, v0;
      build_sbox();
      for (int i = 0; i < 16; i++) begin
         key_b[i] = 8'($urandom);
         key_c[i] = 8'($urandom);
         key_d[i] = 8'($urandom);
      end
      repeat (3) tick();
      check("rst_sbox_en", {31'h0, sbox_en}, 0);
      check("rst_sbox_addr", {24'h0, sbox_addr}, 0);
      check("rst_ready", {31'h0, keys_ready}, 0);
      check("rst_busy", {31'h0, busy}, 0);
      check("rst_rk_valid", {31'h0, rk_valid}, 0);
      check("rst_rk_dout", {24'h0, rk_dout}, 0);
      rst_n = 1'b1;
      tick();

      expand("fips", key_a);
      check("fips_busy_done", {31'h0, busy}, 0);
      stream("fips_r1", 1, r1_f);
      stream("fips_r10", 10, r10_f);
      stream("fips_r0", 0, key_a);

      v0 = vcnt;
      rk_round = 4'd11;
      rk_req   = 1'b1;
      tick();
      rk_req   = 1'b0;
      repeat (20) tick();
      check("bad_round_no_valid", vcnt - v0, 0);
      check("bad_round_ready", {31'h0, keys_ready}, 1);

      v0 = vcnt;
      request(0, key_a);
      repeat (5) tick();
      rk_round = 4'd10;
      rk_req   = 1'b1;
      tick();
      rk_req   = 1'b0;
      repeat (15) tick();
      check("midreq_len", vcnt - v0, 16);
      check("midreq_q_empty", exp_q.size(), 0);
      stream("after_midreq_r10", 10, r10_f);

      model(key_b);
      s0 = scnt;
      load(key_b, 0);
      repeat (20) tick();
      din    = 8'hff;
      din_en = 1'b1;
      tick();
      din_en = 1'b0;
      wait_ready(n);
      check("midexp_latency", n + 21, 90);
      check("midexp_sbox_pulses", scnt - s0, 40);
      get_rk(10, e);
      stream("b_r10", 10, e);
      get_rk(5, e);
      stream("b_r5", 5, e);

      get_rk(3, e);
      request(3, e);
      repeat (4) tick();
      din    = key_c[0];
      din_en = 1'b1;
      tick();
      din_en = 1'b0;
      check("abort_valid", {31'h0, rk_valid}, 0);
      check("abort_ready", {31'h0, keys_ready}, 0);
      check("abort_busy", {31'h0, busy}, 1);
      exp_q.delete();
      model(key_c);
      s0 = scnt;
      load(key_c, 1);
      wait_ready(n);
      check("c_latency", n, 90);
      check("c_sbox_pulses", scnt - s0, 40);
      get_rk(10, e);
      stream("c_r10", 10, e);
      stream("c_r0", 0, key_c);

      load(key_d, 0);
      repeat (40) tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst_sbox_en", {31'h0, sbox_en}, 0);
      check("arst_sbox_addr", {24'h0, sbox_addr}, 0);
      check("arst_busy", {31'h0, busy}, 0);
      check("arst_ready", {31'h0, keys_ready}, 0);
      check("arst_rk_valid", {31'h0, rk_valid}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      expand("d", key_d);
      get_rk(10, e);
      stream("d_r10", 10, e);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
